line_mission_ctrl: RTL and testbench
====================================

LINE_MISSION_CTRL -- requirements
Module: line_mission_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, meaning consecutive equal raw samples needed before the filtered sensor pair updates (range 1..15).
REQ-002 The block SHALL have parameter LOST_CYCLES, default 8, meaning cycles in LOST before SEARCH starts (range 1..255).
REQ-003 The block SHALL have parameter SEARCH_CYCLES, default 64, meaning maximum cycles spent in SEARCH before FAULT (range 1..255).
REQ-004 The block SHALL have parameter PWM_PERIOD, default 16, meaning the PWM counter period in cycles (range 2..256).
REQ-005 The block SHALL have parameter PWM_DUTY, default 12, meaning the PWM high cycles per period (range 0..PWM_PERIOD).
REQ-006 The block SHALL have these ports:
  clk  in  1  system clock, rising edge;
  reset  in  1  asynchronous, active-high reset;
  start  in  1  level, begin or resume following;
  halt  in  1  level, stop and return to IDLE;
  sensorLeft, sensorRight  in  1 each  1 = white surface, 0 = black surface;
  motorLeft, motorRight  out  1 each  motor enables;
  busy  out  1  high in FOLLOW, LOST and SEARCH;
  fault  out  1  high in FAULT;
  state  out  3  IDLE=0, FOLLOW=1, LOST=2, SEARCH=3, FAULT=4.

Function
REQ-007 The filter SHALL update the filtered pair {fl,fr} on the DEBOUNCE-th consecutive rising edge at which the raw pair equals the new value; any raw change restarts the count.
REQ-008 The FSM SHALL have states IDLE, FOLLOW, LOST, SEARCH and FAULT, one registered transition per cycle.
REQ-009 The transitions SHALL be:
  IDLE->FOLLOW on start;
  FOLLOW->LOST when filtered = 00;
  LOST->FOLLOW when filtered != 00;
  LOST->SEARCH after LOST_CYCLES consecutive cycles in LOST;
  SEARCH->FOLLOW when filtered != 00;
  SEARCH->FAULT after SEARCH_CYCLES cycles in SEARCH;
  FAULT->FOLLOW on start.
REQ-010 halt SHALL force IDLE at the next edge from any state, with priority over start and all other transitions.
REQ-011 The LOST and SEARCH dwell counters SHALL clear on state entry and SHALL saturate, never wrap.
REQ-012 In FOLLOW, the steering level {motorLeft,motorRight} SHALL be: filtered 11->11, 01->01 (turn left), 10->10 (turn right).
REQ-013 The register last_dir SHALL record LEFT on each FOLLOW cycle with filtered 01 and RIGHT on each FOLLOW cycle with filtered 10; it holds otherwise.
REQ-014 In SEARCH, the steering level SHALL be 01 if last_dir = LEFT and 10 if last_dir = RIGHT.
REQ-015 In IDLE, LOST and FAULT, the steering level SHALL be 00.
REQ-016 The steering level SHALL be decoded combinationally from the registered state, the filtered pair and last_dir (Moore-style, zero added latency).
REQ-017 busy, fault and state SHALL be decoded from the registered state only.
REQ-018 On a sensor change, the steering SHALL take the new value after exactly DEBOUNCE edges plus one state edge where a transition is involved.

Reset
REQ-019 Reset SHALL set: state=IDLE, filtered pair=11, debounce count=0, dwell counters=0, last_dir=LEFT, PWM counter=0.
REQ-020 During reset, motorLeft=motorRight=0, busy=0, fault=0 and state=0.
REQ-021 Reset asserted mid-SEARCH or mid-FAULT SHALL return the block to IDLE with no memory of the fault.

Configuration
REQ-022 With macro LINE_MISSION_PWM_EN defined, a free-running counter SHALL run 0..PWM_PERIOD-1 and wrap to 0.
REQ-023 With LINE_MISSION_PWM_EN defined, each motor output SHALL be its steering level AND (counter < PWM_DUTY).
REQ-024 With LINE_MISSION_PWM_EN defined, PWM_DUTY=0 SHALL give constant 0 and PWM_DUTY=PWM_PERIOD SHALL give a constant level.
REQ-025 Without LINE_MISSION_PWM_EN, the motor outputs SHALL equal the steering level directly, and no PWM counter SHALL be instantiated.

Verification
REQ-026 Scenario, basic follow: reset, start=1, sensors 11 -> state=1 one edge after start, motors 11 (PWM off build).
REQ-027 Scenario, debounce: in FOLLOW, sensors 01 held 3 cycles then back to 11 -> motors stay 11; 01 held 4 cycles -> motors 01 after the 4th edge.
REQ-028 Scenario, recovery: last turn right, then sensors 00 held -> LOST for 8 cycles, SEARCH with motors 10; sensors 11 restored -> FOLLOW after 4 debounce edges plus 1 state edge.
REQ-029 Scenario, fault: sensors 00 held -> fault=1 and state=4 after 4+1+8+64 edges, motors 00; start -> state=1, fault=0.
REQ-030 Scenario, halt priority: halt=1 with start=1 in SEARCH -> state=0 next edge, motors 00; async reset mid-LOST -> all outputs 0 immediately.
REQ-031 Scenario, PWM: PWM build with defaults, FOLLOW with sensors 11 -> motors high 12 of every 16 cycles, low for counts 12..15.

Source files
------------

// File: rtl/line_mission_ctrl.sv
// Line-following mission controller: debounced sensor pair, follow/lost/search/fault FSM.
// Optional motor PWM gating is enabled by defining LINE_MISSION_PWM_EN.
module line_mission_ctrl #(
  parameter int DEBOUNCE      = 4,
  parameter int LOST_CYCLES   = 8,
  parameter int SEARCH_CYCLES = 64,
  parameter int PWM_PERIOD    = 16,
  parameter int PWM_DUTY      = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       halt,
  input  logic       sensorLeft,
  input  logic       sensorRight,
  output logic       motorLeft,
  output logic       motorRight,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FOLLOW = 3'd1,
    LOST   = 3'd2,
    SEARCH = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t     cur;
  state_t     nxt;
  logic [1:0] raw;
  logic [1:0] cand;
  logic [1:0] filt;
  logic [3:0] db_cnt;
  logic [7:0] dwell;
  logic       last_right;
  logic [1:0] steer;

  assign raw = {sensorLeft, sensorRight};

  // The edge that first sees a new raw value counts as sample one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand   <= 2'b11;
      filt   <= 2'b11;
      db_cnt <= 4'd0;
    end else if (raw != cand) begin
      cand   <= raw;
      db_cnt <= 4'd1;
      if (DEBOUNCE == 1) filt <= raw;
    end else if (db_cnt < 4'(DEBOUNCE)) begin
      db_cnt <= db_cnt + 4'd1;
      if (db_cnt == 4'(DEBOUNCE - 1)) filt <= raw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // dwell holds cycles already spent in the current state, minus one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell <= 8'd0;
    end else if (nxt != cur) begin
      dwell <= 8'd0;
    end else if (dwell != 8'hFF) begin
      dwell <= dwell + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_right <= 1'b0;
    end else if (cur == FOLLOW) begin
      if (filt == 2'b01) last_right <= 1'b0;
      else if (filt == 2'b10) last_right <= 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    if (halt) begin
      nxt = IDLE;
    end else begin
      case (cur)
        IDLE:   if (start) nxt = FOLLOW;
        FOLLOW: if (filt == 2'b00) nxt = LOST;
        LOST: begin
          if (filt != 2'b00) nxt = FOLLOW;
          else if (dwell >= 8'(LOST_CYCLES - 1)) nxt = SEARCH;
        end
        SEARCH: begin
          if (filt != 2'b00) nxt = FOLLOW;
          else if (dwell >= 8'(SEARCH_CYCLES - 1)) nxt = FAULT;
        end
        FAULT:  if (start) nxt = FOLLOW;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    steer = 2'b00;
    unique case (1'b1)
      (cur == FOLLOW): steer = filt;
      (cur == SEARCH): steer = last_right ? 2'b10 : 2'b01;
      default:         steer = 2'b00;
    endcase
  end

  assign busy  = (cur == FOLLOW) || (cur == LOST) || (cur == SEARCH);
  assign fault = (cur == FAULT);
  assign state = cur;

`ifdef LINE_MISSION_PWM_EN
  localparam int PW = $clog2(PWM_PERIOD);

  logic [PW-1:0] pwm_cnt;
  logic          pwm_on;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == PW'(PWM_PERIOD - 1)) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Extra bit lets PWM_DUTY == PWM_PERIOD mean always on.
  assign pwm_on = {1'b0, pwm_cnt} < (PW + 1)'(PWM_DUTY);
  assign {motorLeft, motorRight} = steer & {2{pwm_on}};
`else
  assign {motorLeft, motorRight} = steer;
`endif

endmodule

// File: tb/tb_line_mission_ctrl.sv
// Bench for line_mission_ctrl: directed mission scenarios then random sensor traffic,
// checked every cycle against a cycle-count reference model.
module tb_line_mission_ctrl;

  localparam int D  = 4;
  localparam int LC = 8;
  localparam int SC = 64;
  localparam int PP = 16;
  localparam int PD = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       sensorLeft = 1'b1;
  logic       sensorRight = 1'b1;
  logic       motorLeft;
  logic       motorRight;
  logic       busy;
  logic       fault;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // mode: 0 idle, 1 follow, 2 lost, 3 search, 4 fault
  int       m_mode;
  int       m_time;
  int       m_cnt;
  int       m_pc;
  bit [1:0] m_filt;
  bit [1:0] m_cand;
  bit       m_right;

  line_mission_ctrl #(
    .DEBOUNCE(D), .LOST_CYCLES(LC), .SEARCH_CYCLES(SC),
    .PWM_PERIOD(PP), .PWM_DUTY(PD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .sensorLeft(sensorLeft), .sensorRight(sensorRight),
    .motorLeft(motorLeft), .motorRight(motorRight),
    .busy(busy), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode  = 0;
    m_time  = 1;
    m_cnt   = 0;
    m_pc    = 0;
    m_filt  = 2'b11;
    m_cand  = 2'b11;
    m_right = 1'b0;
  endtask

  task automatic model_edge(bit [1:0] r, bit s, bit h);
    int nm;
    nm = m_mode;
    if (h) nm = 0;
    else case (m_mode)
      0: if (s) nm = 1;
      1: if (m_filt == 0) nm = 1 + 1;
      2: if (m_filt != 0) nm = 1; else if (m_time >= LC) nm = 3;
      3: if (m_filt != 0) nm = 1; else if (m_time >= SC) nm = 4;
      4: if (s) nm = 1;
      default: nm = 0;
    endcase
    if (m_mode == 1 && m_filt == 2'b01) m_right = 1'b0;
    if (m_mode == 1 && m_filt == 2'b10) m_right = 1'b1;
    m_time = (nm != m_mode) ? 1 : m_time + 1;
    m_mode = nm;
    if (r == m_cand) m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
    else begin
      m_cand = r;
      m_cnt  = 1;
    end
    if (m_cnt == D) m_filt = r;
    m_pc = (m_pc + 1) % PP;
  endtask

  function automatic logic [6:0] expected();
    logic [1:0] st;
    logic [2:0] md;
    md = m_mode[2:0];
    st = 2'b00;
    if (m_mode == 1) st = m_filt;
    if (m_mode == 3) st = m_right ? 2'b10 : 2'b01;
`ifdef LINE_MISSION_PWM_EN
    if (!(m_pc < PD)) st = 2'b00;
`endif
    return {md, 1'(m_mode >= 1 && m_mode <= 3), 1'(m_mode == 4), st};
  endfunction

  function automatic logic [6:0] observed();
    return {state, busy, fault, motorLeft, motorRight};
  endfunction

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(string tag, logic [2:0] exp);
    checks++;
    assert (state === exp) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp);
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    if (!reset) model_edge({sensorLeft, sensorRight}, start, halt);
    #1;
    chk(tag, observed(), expected());
  endtask

  task automatic ticks(string tag, int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic sens(bit [1:0] v);
    {sensorLeft, sensorRight} = v;
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_outputs", observed(), 7'd0);
    ticks("in_reset", 2);
    reset = 1'b0;

    start = 1'b1;
    tick("start");
    chk_state("follow_after_start", 3'd1);
    start = 1'b0;
    ticks("follow11", 3);

    sens(2'b01);
    ticks("db_short", 3);
    sens(2'b11);
    tick("db_short_back");
    ticks("db_hold", 3);
    sens(2'b01);
    ticks("db_long", 3);
    chk_state("db_before_4th", 3'd1);
    tick("db_4th");
`ifndef LINE_MISSION_PWM_EN
    chk("motors_01", {state, motorLeft, motorRight}, {3'd1, 2'b01});
`endif

    sens(2'b10);
    ticks("turn_right", 4);
    sens(2'b00);
    ticks("to_lost", 5);
    chk_state("lost_entry", 3'd2);
    ticks("lost_dwell", 7);
    chk_state("still_lost", 3'd2);
    tick("search_entry");
    chk_state("search", 3'd3);
    ticks("search_run", 3);
    sens(2'b11);
    ticks("recover_db", 4);
    chk_state("recover_pending", 3'd3);
    tick("recover");
    chk_state("recovered", 3'd1);

    sens(2'b00);
    ticks("to_fault", 76);
    chk_state("pre_fault", 3'd3);
    tick("fault_entry");
    chk_state("fault", 3'd4);
    ticks("fault_hold", 5);
    start = 1'b1;
    tick("fault_restart");
    chk_state("restart_follow", 3'd1);
    start = 1'b0;

    ticks("to_search2", 9);
    chk_state("search2", 3'd3);
    halt  = 1'b1;
    start = 1'b1;
    tick("halt_prio");
    chk_state("halted", 3'd0);
    halt = 1'b0;

    sens(2'b11);
    ticks("relaunch", 2);
    start = 1'b0;
    chk_state("lost_again", 3'd2);
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset", observed(), 7'd0);
    tick("held_reset");
    reset = 1'b0;

    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 5) == 0) sens(2'($urandom_range(0, 3)));
      start = ($urandom_range(0, 7) == 0);
      halt  = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 250) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        chk("rand_reset", observed(), 7'd0);
        tick("rand_in_reset");
        reset = 1'b0;
      end
      tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
